// File: rtl/bpred_pkg.sv
// Shared types for the branch resolve queue: predictor index width, queue entry, mispredict test.
package bpred_pkg;

    localparam int BP_ENTRIES = 1024;
    localparam int IDX_W      = $clog2(BP_ENTRIES);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             pred_taken;
        logic [31:0]      pred_target;
        logic [31:0]      pc_plus4;
    } brn_entry_t;

    // A taken/taken pair still mispredicts when the BTB target was stale.
    function automatic logic is_mispredict(input brn_entry_t e,
                                           input logic       taken,
                                           input logic [31:0] target);
        return (e.pred_taken != taken) ||
               (e.pred_taken && taken && (e.pred_target != target));
    endfunction

endpackage

// File: rtl/brn_mispredict_chk.sv
// Combinational score of the oldest entry against the resolved outcome; yields the
// mispredict flag and the PC fetch must restart from.
module brn_mispredict_chk
    import bpred_pkg::*;
(
    input  brn_entry_t  entry_i,
    input  logic        res_taken_i,
    input  logic [31:0] res_target_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o
);

    assign mispredict_o  = is_mispredict(entry_i, res_taken_i, res_target_i);
    assign redirect_pc_o = res_taken_i ? res_target_i : entry_i.pc_plus4;

endmodule

// File: rtl/brn_resolve_queue.sv
// In-order queue of branch predictions; pops on resolve, drives predictor update and
// redirect one cycle later, and flushes younger entries on a mispredict.
module brn_resolve_queue
    import bpred_pkg::*;
#(
    parameter int NUM_ENTRIES = BP_ENTRIES,
    parameter int DEPTH       = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push_valid_i,
    output logic                           push_ready_o,
    input  logic [$clog2(NUM_ENTRIES)-1:0] push_idx_i,
    input  logic                           push_pred_taken_i,
    input  logic [31:0]                    push_pred_target_i,
    input  logic [31:0]                    push_pc_plus4_i,
    input  logic                           res_valid_i,
    input  logic                           res_taken_i,
    input  logic [31:0]                    res_target_i,
    output logic                           brn_ex_mem_bpred_o,
    output logic [$clog2(NUM_ENTRIES)-1:0] brn_fdback_addr_bpred_o,
    output logic                           brn_fdback_bpred_o,
    output logic [31:0]                    brn_btb_addr_bpred_o,
    output logic                           redirect_valid_o,
    output logic [31:0]                    redirect_pc_o,
    output logic [$clog2(DEPTH):0]         count_o,
    output logic                           underflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    brn_entry_t                    mem_q [DEPTH];
    logic [PW-1:0]                 rd_q, wr_q, rd_d, wr_d;
    logic                          upd_vld_q, fdback_q, redir_vld_q, underflow_q;
    logic [$clog2(NUM_ENTRIES)-1:0] addr_q;
    logic [31:0]                   btb_q, redir_pc_q;

    brn_entry_t  head, push_entry;
    logic        full, empty, pop, mis, push_acc;
    logic [31:0] chk_pc;

    assign full  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty = (wr_q == rd_q);
    assign head  = mem_q[rd_q[AW-1:0]];
    assign pop   = res_valid_i && !empty;

    brn_mispredict_chk u_chk (
        .entry_i       (head),
        .res_taken_i   (res_taken_i),
        .res_target_i  (res_target_i),
        .mispredict_o  (mis),
        .redirect_pc_o (chk_pc)
    );

    // A push alongside a mispredicting pop is on the wrong path and is dropped.
    assign push_acc = push_valid_i && !full && !(pop && mis);

    always_comb begin
        push_entry.idx         = push_idx_i;
        push_entry.pred_taken  = push_pred_taken_i;
        push_entry.pred_target = push_pred_target_i;
        push_entry.pc_plus4    = push_pc_plus4_i;
    end

    always_comb begin
        rd_d = rd_q;
        wr_d = wr_q;
        if (pop && mis) begin
            rd_d = rd_q + PTR_ONE;
            wr_d = rd_q + PTR_ONE;
        end else begin
            if (push_acc) wr_d = wr_q + PTR_ONE;
            if (pop)      rd_d = rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_q[AW-1:0]] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q        <= '0;
            wr_q        <= '0;
            upd_vld_q   <= 1'b0;
            addr_q      <= '0;
            fdback_q    <= 1'b0;
            btb_q       <= '0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            upd_vld_q   <= pop;
            redir_vld_q <= pop && mis;
            if (pop) begin
                addr_q   <= head.idx;
                fdback_q <= res_taken_i;
            end
            if (pop && res_taken_i) btb_q      <= res_target_i;
            if (pop && mis)         redir_pc_q <= chk_pc;
            if (res_valid_i && empty) underflow_q <= 1'b1;
        end
    end

    assign push_ready_o            = !full;
    assign count_o                 = wr_q - rd_q;
    assign brn_ex_mem_bpred_o      = upd_vld_q;
    assign brn_fdback_addr_bpred_o = addr_q;
    assign brn_fdback_bpred_o      = fdback_q;
    assign brn_btb_addr_bpred_o    = btb_q;
    assign redirect_valid_o        = redir_vld_q;
    assign redirect_pc_o           = redir_pc_q;
    assign underflow_o             = underflow_q;

endmodule

// File: tb/tb_brn_resolve_queue.sv
// Directed scoreboard bench: resolves queue an expected update record, a negedge monitor checks it.
module tb_brn_resolve_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid_i, push_ready_o, push_pred_taken_i;
    logic [9:0]  push_idx_i;
    logic [31:0] push_pred_target_i, push_pc_plus4_i;
    logic        res_valid_i, res_taken_i;
    logic [31:0] res_target_i;
    logic        brn_ex_mem_bpred_o, brn_fdback_bpred_o, redirect_valid_o, underflow_o;
    logic [9:0]  brn_fdback_addr_bpred_o;
    logic [31:0] brn_btb_addr_bpred_o, redirect_pc_o;
    logic [2:0]  count_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [9:0]  addr;
        logic        fd;
        logic [31:0] btb;
        logic        red;
        logic [31:0] rpc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    brn_resolve_queue dut (
        .clk                     (clk),
        .reset                   (reset),
        .push_valid_i            (push_valid_i),
        .push_ready_o            (push_ready_o),
        .push_idx_i              (push_idx_i),
        .push_pred_taken_i       (push_pred_taken_i),
        .push_pred_target_i      (push_pred_target_i),
        .push_pc_plus4_i         (push_pc_plus4_i),
        .res_valid_i             (res_valid_i),
        .res_taken_i             (res_taken_i),
        .res_target_i            (res_target_i),
        .brn_ex_mem_bpred_o      (brn_ex_mem_bpred_o),
        .brn_fdback_addr_bpred_o (brn_fdback_addr_bpred_o),
        .brn_fdback_bpred_o      (brn_fdback_bpred_o),
        .brn_btb_addr_bpred_o    (brn_btb_addr_bpred_o),
        .redirect_valid_o        (redirect_valid_o),
        .redirect_pc_o           (redirect_pc_o),
        .count_o                 (count_o),
        .underflow_o             (underflow_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_upd(input logic [9:0] addr, input logic fd, input logic [31:0] btb,
                              input logic red, input logic [31:0] rpc);
        exp_t e;
        e.addr = addr; e.fd = fd; e.btb = btb; e.red = red; e.rpc = rpc;
        sb.push_back(e);
    endtask

    // One clock of stimulus; inputs are applied 1ns after an edge and sampled at the next.
    task automatic drive(input logic pv, input logic [9:0] idx, input logic pt,
                         input logic [31:0] ptgt, input logic [31:0] pc4,
                         input logic rv, input logic rt, input logic [31:0] rtgt);
        push_valid_i = pv; push_idx_i = idx; push_pred_taken_i = pt;
        push_pred_target_i = ptgt; push_pc_plus4_i = pc4;
        res_valid_i = rv; res_taken_i = rt; res_target_i = rtgt;
        @(posedge clk);
        #1;
        push_valid_i = 1'b0;
        res_valid_i  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_count"},  32'(count_o), 0);
        chk({tag, "_ready"},  32'(push_ready_o), 1);
        chk({tag, "_strobe"}, 32'(brn_ex_mem_bpred_o), 0);
        chk({tag, "_redir"},  32'(redirect_valid_o), 0);
        chk({tag, "_uflow"},  32'(underflow_o), 0);
        chk({tag, "_addr"},   32'(brn_fdback_addr_bpred_o), 0);
        chk({tag, "_fdback"}, 32'(brn_fdback_bpred_o), 0);
        chk({tag, "_btb"},    brn_btb_addr_bpred_o, 0);
        chk({tag, "_rpc"},    redirect_pc_o, 0);
    endtask

    always @(negedge clk) begin
        if (brn_ex_mem_bpred_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_strobe: got strobe addr %0h expected none", brn_fdback_addr_bpred_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("upd_addr",   32'(brn_fdback_addr_bpred_o), 32'(e.addr));
                chk("upd_fdback", 32'(brn_fdback_bpred_o), 32'(e.fd));
                chk("upd_btb",    brn_btb_addr_bpred_o, e.btb);
                chk("upd_redir",  32'(redirect_valid_o), 32'(e.red));
                if (e.red) chk("redir_pc", redirect_pc_o, e.rpc);
            end
        end else if (redirect_valid_o === 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL stray_redirect: got redirect without strobe expected none");
        end
    end

    initial begin
        reset = 1'b1;
        push_valid_i = 0; push_idx_i = 0; push_pred_taken_i = 0;
        push_pred_target_i = 0; push_pc_plus4_i = 0;
        res_valid_i = 0; res_taken_i = 0; res_target_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Fill to capacity, then a fifth push must be ignored.
        for (int i = 1; i <= 4; i++)
            drive(1, 10'(i), 0, 32'h900, 32'(16 * i), 0, 0, 0);
        chk("full_count", 32'(count_o), 4);
        chk("full_ready", 32'(push_ready_o), 0);
        drive(1, 10'd9, 0, 0, 32'h99, 0, 0, 0);
        chk("full_push_ignored", 32'(count_o), 4);

        // Resolve while full with a push offered: ready stays low, push is lost.
        push_valid_i = 1; push_idx_i = 10'd9; res_valid_i = 1;
        #1;
        chk("full_res_ready", 32'(push_ready_o), 0);
        expect_upd(10'd1, 0, 0, 0, 0);
        drive(1, 10'd9, 0, 0, 32'h99, 1, 0, 32'h0);
        chk("full_res_count", 32'(count_o), 3);
        for (int i = 2; i <= 4; i++) begin
            expect_upd(10'(i), 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 1, 0, 32'h0);
        end
        chk("drain_count", 32'(count_o), 0);

        // Correct taken prediction.
        drive(1, 10'd5, 1, 32'h100, 32'h58, 0, 0, 0);
        expect_upd(10'd5, 1, 32'h100, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 32'h100);

        // Not-taken predicted, taken actual: flush two younger entries.
        drive(1, 10'd7, 0, 0, 32'h44, 0, 0, 0);
        drive(1, 10'd8, 0, 0, 32'h48, 0, 0, 0);
        drive(1, 10'd9, 0, 0, 32'h4c, 0, 0, 0);
        expect_upd(10'd7, 1, 32'h200, 1, 32'h200);
        drive(0, 0, 0, 0, 0, 1, 1, 32'h200);
        chk("flush_count", 32'(count_o), 0);

        // Taken predicted, not-taken actual: redirect to fall-through, BTB held.
        drive(1, 10'd10, 1, 32'h80, 32'h24, 0, 0, 0);
        expect_upd(10'd10, 0, 32'h200, 1, 32'h24);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h999);
        chk("nt_flush_count", 32'(count_o), 0);

        // Mispredict with same-cycle push: push dropped.
        drive(1, 10'd11, 0, 0, 32'h30, 0, 0, 0);
        expect_upd(10'd11, 1, 32'h300, 1, 32'h300);
        drive(1, 10'd12, 0, 0, 32'h34, 1, 1, 32'h300);
        chk("mis_push_drop", 32'(count_o), 0);

        // Correct resolve with same-cycle push: count constant.
        drive(1, 10'd13, 1, 32'h400, 32'h50, 0, 0, 0);
        chk("pre_sim_count", 32'(count_o), 1);
        expect_upd(10'd13, 1, 32'h400, 0, 0);
        drive(1, 10'd14, 0, 0, 32'h60, 1, 1, 32'h400);
        chk("sim_count", 32'(count_o), 1);
        expect_upd(10'd14, 0, 32'h400, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h0);

        // Both taken but target differs.
        drive(1, 10'd15, 1, 32'h500, 32'h70, 0, 0, 0);
        expect_upd(10'd15, 1, 32'h504, 1, 32'h504);
        drive(0, 0, 0, 0, 0, 1, 1, 32'h504);
        chk("tgt_flush_count", 32'(count_o), 0);

        // Resolve into empty queue: underflow, sticky, no strobe.
        chk("pre_uflow", 32'(underflow_o), 0);
        drive(0, 0, 0, 0, 0, 1, 1, 32'h600);
        chk("uflow_set", 32'(underflow_o), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("uflow_sticky", 32'(underflow_o), 1);
        drive(1, 10'd16, 0, 0, 32'h80, 1, 0, 32'h0);
        chk("uflow_push_count", 32'(count_o), 1);
        drive(1, 10'd17, 0, 0, 32'h84, 0, 0, 0);
        chk("pre_rst_count", 32'(count_o), 2);

        // Reset mid-queue, with a resolve offered on the reset edge.
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 0, 32'h0);
        check_all_zero("midrst");
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_count", 32'(count_o), 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_pending", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/brn_resolve_queue.md
# brn_resolve_queue

In-order tracking queue between decode and the execute/memory stage that records every branch's prediction and scores it against the resolved outcome. Each entry holds the prediction made by the one-level 2-bit-counter predictor. When a branch resolves, the queue pops the oldest entry and drives the predictor's update port one cycle later. On a misprediction it raises a redirect with the correct next PC and flushes all younger entries.

## Interface
- NUM_ENTRIES, 1024: predictor table size; index width is $clog2(NUM_ENTRIES).
- DEPTH, 4: queue entries (power of two, ≥2).
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- push_valid_i  in  1  decoded branch enters queue
- push_ready_o  out  1  queue not full
- push_idx_i  in  $clog2(NUM_ENTRIES)  predictor index of branch
- push_pred_taken_i  in  1  predicted direction
- push_pred_target_i  in  32  predicted target (BTB output)
- push_pc_plus4_i  in  32  fall-through PC
- res_valid_i  in  1  oldest in-flight branch resolved this cycle
- res_taken_i  in  1  actual direction
- res_target_i  in  32  actual target
- brn_ex_mem_bpred_o  out  1  predictor update strobe
- brn_fdback_addr_bpred_o  out  $clog2(NUM_ENTRIES)  index to update
- brn_fdback_bpred_o  out  1  actual direction, used as counter increment (1) or decrement (0)
- brn_btb_addr_bpred_o  out  32  BTB write data (actual target)
- redirect_valid_o  out  1  mispredict; fetch must load redirect_pc_o
- redirect_pc_o  out  32  correct next PC
- count_o  out  $clog2(DEPTH)+1  occupancy
- underflow_o  out  1  sticky: resolve seen while empty

## Operation
- Circular buffer: rd_ptr and wr_ptr, each $clog2(DEPTH)+1 bits. Full when the pointer MSBs differ and the low bits are equal. Empty when the pointers are equal.
- Push is accepted when push_valid_i && push_ready_o. Data is written at wr_ptr, and wr_ptr increments.
- Resolve pops the entry at rd_ptr. res_valid_i asserts only in order.
- A misprediction is any of:
  - pred_taken != res_taken_i;
  - both directions taken and pred_target != res_target_i.
- Next-cycle update outputs, registered:
  - brn_ex_mem_bpred_o=1
  - brn_fdback_addr_bpred_o=entry idx
  - brn_fdback_bpred_o=res_taken_i
  - brn_btb_addr_bpred_o = res_target_i if taken, else the held previous value
- On a misprediction, next cycle:
  - redirect_valid_o=1
  - redirect_pc_o = res_taken_i ? res_target_i : pc_plus4
  - all entries younger than the popped one are discarded: wr_ptr <= rd_ptr+1 and rd_ptr <= rd_ptr+1 in the resolve cycle.
- Flush beats push. A push in the same cycle as a mispredicting resolve is dropped, because that instruction is on the wrong path.
- Simultaneous push and correct resolve: both take effect, and count is unchanged.
- Push while full: ignored, with no pointer change. The producer must stall on push_ready_o=0.
- Resolve while empty: no pop and no update strobe. underflow_o sets and is cleared only by reset.
- Full with a resolve in the same cycle: push_ready_o stays 0 that cycle. Ready is derived only from current occupancy, with no combinational path from res_valid_i.

## Timing
- Reset, next edge:
  - rd_ptr=wr_ptr=0, count_o=0, push_ready_o=1.
  - Strobe outputs are 0: brn_ex_mem_bpred_o, redirect_valid_o, underflow_o.
  - Data outputs are 0: brn_fdback_addr_bpred_o, brn_fdback_bpred_o, brn_btb_addr_bpred_o, redirect_pc_o.
- Reset mid-operation discards all entries. Strobes are low on the cycle after reset.
- Latency: resolve edge T produces update outputs and the redirect valid during cycle T+1. Both strobes are single-cycle pulses.
- Back-to-back resolves produce back-to-back update strobes, giving 1 update per cycle throughput.
- A pushed entry is visible to a resolve on the following cycle, not the same cycle. Resolving into an empty queue with a same-cycle push counts as underflow.

## Structure
- Shared package bpred_pkg: index-width localparam, entry struct {idx, pred_taken, pred_target, pc_plus4}, and a mispredict-check function.
- One sub-module, brn_mispredict_chk: combinational compare of the entry against the resolved outcome, producing mispredict and redirect_pc.
- Storage is a register array. No memory macro.

## Test plan
- Reset, then push 4 entries (idx 1..4, not-taken predictions) → count_o=4, push_ready_o=0. A fifth push is ignored and count stays 4.
- Push idx 5 predicted taken to 0x100, then resolve taken to 0x100 → next cycle brn_ex_mem_bpred_o=1, addr=5, fdback=1, btb=0x100, redirect_valid_o=0.
- Push idx 7 predicted not-taken with pc_plus4=0x44, plus 2 younger entries. Resolve taken to 0x200 → redirect_valid_o=1, redirect_pc_o=0x200, count_o=0 after the flush.
- Predicted taken to 0x80, resolved not-taken with pc_plus4=0x24 → redirect_pc_o=0x24, fdback=0.
- Mispredicting resolve with a same-cycle push → the push is dropped and count_o=0. A same-cycle push with a correct resolve keeps count_o constant.
- Resolve while empty → underflow_o=1 and sticky, no update strobe. Assert reset mid-queue → all outputs 0 on the next cycle.
